// File: rtl/counter_run_ctrl_if.sv
// Host-side start/done handshake of counter_run_ctrl.
// The host drives the master side and the controller uses the slave side.
interface counter_run_ctrl_if #(
    parameter int LAP_W = 8
);
    logic             start;
    logic [LAP_W-1:0] laps;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [LAP_W-1:0] lap_cnt;

    modport master (
        output start, laps, abort,
        input  busy, done, aborted, lap_cnt
    );

    modport slave (
        input  start, laps, abort,
        output busy, done, aborted, lap_cnt
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller for one shared Counter: gates enb and counts carryout laps until the requested count is reached.
// Optional abort path is compiled in with `define COUNTER_RUN_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; lap_cnt holds the last run's result
// ARM   | one settling cycle, counter still disabled
// RUN   | counter enabled, carryout pulses counted as laps
// DONE  | one-cycle done pulse, counter disabled
module counter_run_ctrl #(
    parameter int LAP_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_run_ctrl_if.slave   bus,
    input  logic                ctr_carryout,
    output logic                ctr_enb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAP_W-1:0] laps_q;
    logic [LAP_W-1:0] lap_cnt;
    logic [LAP_W-1:0] lap_nxt;
    logic             lap_load;
    logic             lap_inc;
    logic             abort_hit;
    logic             aborted_q;

    assign lap_nxt = lap_cnt + LAP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lap_load  = 1'b0;
        lap_inc   = 1'b0;
        abort_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    lap_load  = 1'b1;
                    state_nxt = (bus.laps == '0) ? DONE : ARM;
                end
            end
            ARM: begin
                state_nxt = RUN;
`ifdef COUNTER_RUN_CTRL_ABORT_EN
                if (bus.abort) begin
                    abort_hit = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            RUN: begin
                if (ctr_carryout) begin
                    lap_inc = 1'b1;
                    if (lap_nxt == laps_q) begin
                        state_nxt = DONE;
                    end
                end
`ifdef COUNTER_RUN_CTRL_ABORT_EN
                // abort overrides completion, but the final carryout is still counted above
                if (bus.abort) begin
                    abort_hit = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            laps_q  <= '0;
            lap_cnt <= '0;
        end else if (lap_load) begin
            laps_q  <= bus.laps;
            lap_cnt <= '0;
        end else if (lap_inc) begin
            lap_cnt <= lap_nxt;
        end
    end

`ifdef COUNTER_RUN_CTRL_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else if (lap_load) begin
            aborted_q <= 1'b0;
        end else if (abort_hit) begin
            aborted_q <= 1'b1;
        end
    end
`else
    logic abort_unused;
    logic abort_hit_unused;
    assign abort_unused     = bus.abort;
    assign abort_hit_unused = abort_hit;
    assign aborted_q        = 1'b0;
`endif

    assign ctr_enb     = (state == RUN);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.aborted = aborted_q;
    assign bus.lap_cnt = lap_cnt;

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run controller that sequences one shared `Counter` instance: it accepts a start request carrying a lap count, gates the counter's `enb`, counts `carryout` pulses, and reports completion with a one-cycle `done` pulse. It sits between the test scenario (or any host FSM) and the `Counter` DUT, replacing hand-written start/stop sequencing with a reusable start/done handshake.

## Interface
- `LAP_W`, default 8: width of the lap-count request and of the lap counter.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  run request; accepted only in IDLE.
- `laps`  in  LAP_W  number of counter wraps to run; sampled with an accepted `start`.
- `abort`  in  1  cancel the current run (see Configuration).
- `ctr_carryout`  in  1  `carryout` from the controlled `Counter`.
- `ctr_enb`  out  1  drives `Counter.enb`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: run ended by `abort`.
- `lap_cnt`  out  LAP_W  completed laps of the current/last run.

## Operation
- States: IDLE, ARM, RUN, DONE (registered; outputs decoded from state plus registered flags).
- IDLE: `start`=1 -> latch `laps` into `laps_q`, clear `lap_cnt` and `aborted`, go ARM; if `laps`=0 go directly to DONE (no counter enable, `lap_cnt` stays 0).
- ARM: one settling cycle, `ctr_enb`=0, unconditionally -> RUN.
- RUN: `ctr_enb`=1. Each cycle with `ctr_carryout`=1: `lap_cnt` += 1; if `lap_cnt`+1 == `laps_q` -> DONE.
- DONE: `done`=1, `ctr_enb`=0, -> IDLE next cycle.
- `ctr_carryout` ignored in every state except RUN.
- `start` while `busy`=1: ignored, not queued.
- `ctr_enb` = (state == RUN); `busy` = (state != IDLE); `done` = (state == DONE).
- `lap_cnt` holds its final value in IDLE until the next accepted start.
- Normal completion leaves the counter wrapped at 0; the next run needs no counter reset.
- Reset (any time, including mid-run): state IDLE, `ctr_enb`=0, `busy`=0, `done`=0, `aborted`=0, `lap_cnt`=0, `laps_q`=0.

## Timing
- Edge E0 samples `start`=1 in IDLE -> ARM during cycle after E0; RUN from E1; `ctr_enb` high from E1.
- Final-lap `carryout` high in cycle before edge Ek -> DONE after Ek, `ctr_enb` low in the same cycle; IDLE after Ek+1.
- Start-to-first-enable latency: 2 cycles; carryout-to-done latency: 1 cycle; `done` width exactly 1 cycle.
- Earliest re-accept of `start`: the edge ending the DONE cycle is not an accept point; first accept at Ek+2.
- `laps`=0: DONE after E0, `done` high one cycle after E0.
- `laps`=2^LAP_W-1 is the maximum; `lap_cnt` never wraps within a run.

## Configuration
- Macro `COUNTER_RUN_CTRL_ABORT_EN`.
- Defined: `abort`=1 in ARM or RUN -> DONE next edge with `aborted`=1; `abort` wins over a simultaneous final `carryout` (`lap_cnt` still counts that carryout); `abort` in IDLE/DONE ignored. Counter may be left at a non-zero count; owner must reset it before the next run.
- Not defined: `abort` port present but ignored; `aborted` tied 0.

## Test plan
- Counter WIDTH=2, `laps`=3, `start` pulse at E0 -> `ctr_enb` high E1..E13, `done`=1 only in cycle after E13, `lap_cnt`=3, `aborted`=0, `busy` low after E14.
- `laps`=0 at E0 -> `done` in cycle after E0, `ctr_enb` never high, `lap_cnt`=0.
- `start` held high throughout a `laps`=1 run -> exactly one run, next accept at the edge after IDLE re-entry; no extra `done`.
- `rst_n` low for 1 cycle mid-RUN (`lap_cnt`=1) -> all outputs 0 immediately, state IDLE; new `start` runs normally.
- ABORT_EN: `abort` at same edge as 2nd carryout of `laps`=2 -> `done`=1, `aborted`=1, `lap_cnt`=2; without macro same stimulus -> `aborted`=0.
- `ctr_carryout` forced high in IDLE/ARM -> `lap_cnt` unchanged, no state change beyond ARM->RUN.
